// File: rtl/secondary_input_top.sv
// Montgomery constant precompute: n0p = -n^-1 mod 2^WW, r = 2^NW mod n, t = 2^(2NW) mod n.
// One modular doubling per cycle for 2*NW cycles; n0p by Newton iteration alongside.
module secondary_input_top #(
    parameter int NW = 1024,
    parameter int WW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n,
    output logic [WW-1:0] n0p,
    output logic [NW-1:0] r,
    output logic [NW-1:0] t,
    output logic          done
);
    localparam int CW = $clog2(2*NW) + 1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [NW-1:0] nreg, x, x_nx, diff;
    logic [NW:0]   x2;
    logic [CW-1:0] cnt, cnt_nx;
    logic [WW-1:0] y;
    logic          accept, step, fin, ge;

    assign x2     = {x, 1'b0};
    assign ge     = (x2 >= {1'b0, nreg});
    // x < nreg keeps 2x - nreg below 2^NW, so the truncated subtract is exact
    assign diff   = x2[NW-1:0] - nreg;
    assign x_nx   = ge ? diff : x2[NW-1:0];
    assign cnt_nx = cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (cnt_nx == CW'(2*NW)) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nreg <= '0;
            x    <= '0;
            cnt  <= '0;
            y    <= '0;
            n0p  <= '0;
            r    <= '0;
            t    <= '0;
            done <= 1'b0;
        end else begin
            if (accept) begin
                nreg <= n;
                // start from 1 mod n so that n = 1 yields r = t = 0
                x    <= (n == NW'(1)) ? '0 : NW'(1);
                cnt  <= '0;
                y    <= WW'(1);
                done <= 1'b0;
            end
            if (step) begin
                x   <= x_nx;
                cnt <= cnt_nx;
                // each Newton step doubles the correct low bits: 1,2,4,8,16,32
                if (cnt < CW'(5))
                    y <= y * (WW'(2) - nreg[WW-1:0] * y);
                if (cnt_nx == CW'(NW))
                    r <= x_nx;
                if (fin) begin
                    t    <= x_nx;
                    n0p  <= WW'(0) - y;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_secondary_input_top.sv
// Self-checking bench for secondary_input_top: directed moduli, handshake/latency,
// mid-run reset and random moduli against a wide-arithmetic reference.
module tb_secondary_input_top;
    localparam int NW = 1024;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] n = '0;
    logic [WW-1:0] n0p;
    logic [NW-1:0] r, t;
    logic          done;

    int compared = 0;
    int mism = 0;

    secondary_input_top #(.NW(NW), .WW(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n),
        .n0p(n0p), .r(r), .t(t), .done(done)
    );

    always #5 clk = ~clk;

    // reference: 2^e mod m by plain wide division
    function automatic logic [NW-1:0] powmod(input int e, input logic [NW-1:0] m);
        logic [2*NW:0] p, mm;
        p    = '0;
        p[e] = 1'b1;
        mm   = {{(NW+1){1'b0}}, m};
        p    = p % mm;
        return p[NW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: got ..%h exp ..%h (low 96 bits)", tag, obs[95:0], exp[95:0]);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: got %0d exp %0d", tag, obs, exp);
        end
    endtask

    // full run: start at E0, optional start poke at E500 and n scrambling, then check results
    task automatic run(input string tag, input logic [NW-1:0] nv, input bit poke,
                       input bit chk_exact, input logic [WW-1:0] exp_n0p);
        int k;
        logic [WW-1:0] prod;
        logic [NW-1:0] er, et;
        er = powmod(NW, nv);
        et = powmod(2*NW, nv);
        @(negedge clk);
        n = nv;
        start = 1'b1;
        @(posedge clk); #1;
        chk_int({tag, ":done_low_E0"}, int'(done), 0);
        k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            start = poke && (k == 499);
            if (poke) n = ~nv ^ {(NW/32){$urandom()}};
            @(posedge clk); #1;
            k++;
        end
        chk_int({tag, ":latency"}, k, 2*NW);
        chk({tag, ":r"}, r, er);
        chk({tag, ":t"}, t, et);
        if (nv[0]) begin
            prod = n0p * nv[WW-1:0];
            chk({tag, ":n0p_inv"}, NW'(prod), NW'(32'hFFFF_FFFF));
        end
        if (chk_exact) chk({tag, ":n0p"}, NW'(n0p), NW'(exp_n0p));
        repeat (5) @(posedge clk);
        #1;
        chk_int({tag, ":done_hold"}, int'(done), 1);
        chk({tag, ":r_hold"}, r, er);
    endtask

    initial begin
        logic [NW-1:0] v;
        int k, highs;

        repeat (3) @(posedge clk);
        #1;
        chk_int("reset:done", int'(done), 0);
        chk("reset:r", r, '0);
        chk("reset:t", t, '0);
        chk("reset:n0p", NW'(n0p), '0);
        @(negedge clk);
        rst = 1'b0;

        v = '1;
        run("all_ones", v, 1'b0, 1'b1, 32'h0000_0001);
        chk("all_ones:r_const", r, NW'(1));
        chk("all_ones:t_const", t, NW'(1));

        v = '0; v[NW-1] = 1'b1; v[0] = 1'b1;
        run("half_plus1", v, 1'b0, 1'b1, 32'hFFFF_FFFF);
        v = '0; v[NW-1] = 1'b1; v = v - NW'(1);
        chk("half_plus1:r_const", r, v);
        chk("half_plus1:t_const", t, NW'(4));

        run("three", NW'(3), 1'b0, 1'b1, 32'h5555_5555);
        chk("three:r_const", r, NW'(1));
        chk("three:t_const", t, NW'(1));

        // start at E500 ignored, n changes after E0 ignored
        for (int i = 0; i < NW/32; i++) v[i*32 +: 32] = $urandom();
        v[0] = 1'b1; v[NW-1] = 1'b1;
        run("poke", v, 1'b1, 1'b0, '0);

        // reset at step 1000
        for (int i = 0; i < NW/32; i++) v[i*32 +: 32] = $urandom();
        v[0] = 1'b1;
        @(negedge clk);
        n = v; start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (k < 1000) begin
            @(negedge clk); start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_int("midrst:done", int'(done), 0);
        chk("midrst:r", r, '0);
        chk("midrst:t", t, '0);
        chk("midrst:n0p", NW'(n0p), '0);
        @(negedge clk); rst = 1'b0;
        highs = 0;
        repeat (2*NW + 20) begin
            @(posedge clk); #1;
            if (done) highs++;
        end
        chk_int("midrst:no_done", highs, 0);
        run("after_rst", v, 1'b0, 1'b0, '0);

        run("n_one", NW'(1), 1'b0, 1'b0, '0);

        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < NW/32; i++) v[i*32 +: 32] = $urandom();
            v[0] = 1'b1;
            if (j < 3) v[NW-1] = 1'b1;
            run($sformatf("rand%0d", j), v, 1'b0, 1'b0, '0);
        end

        for (int i = 0; i < NW/32; i++) v[i*32 +: 32] = $urandom();
        v[0] = 1'b0; v[NW-1] = 1'b1;
        run("even", v, 1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
